// File: rtl/omsp_cycle_profiler.sv
// rtl/omsp_cycle_profiler.sv - multi-channel cycle-count profiler on the openMSP430 peripheral bus
// Optional feature macro PROFILER_SNAPSHOT_EN adds CTL SNAP/SRD counter snapshots.
module omsp_cycle_profiler #(
   parameter logic [14:0] BASE_ADDR = 15'h0180,
   parameter int          NUM_CH    = 4,
   parameter int          CNT_W     = 32
) (
   input  logic        mclk,
   input  logic        puc_rst,
   input  logic [13:0] per_addr,
   input  logic [15:0] per_din,
   input  logic        per_en,
   input  logic [1:0]  per_we,
   input  logic        dbg_freeze,
   output logic [15:0] per_dout,
   output logic        irq
);

   logic              sel, rd, wr, ctl_wr, clr, tick, cnt_en, srd, gen, ie;
   logic [4:0]        reg_off;
   logic [1:0]        pre_sel;
   logic [2:0]        pre_cnt, pre_mask;
   logic [NUM_CH-1:0] run, ifg, inc, ovf, lo_hit, hi_hit, wr_hit, ifg_clr;
   logic [CNT_W-1:0]  cnt     [NUM_CH];
   logic [31:0]       cnt_ext [NUM_CH];
   logic [31:0]       cnt_wr  [NUM_CH];
   logic [31:0]       view    [NUM_CH];
   logic [15:0]       shadow  [NUM_CH];

   assign sel      = per_en && (per_addr[13:5] == BASE_ADDR[14:6]);
   assign reg_off  = per_addr[4:0];
   assign rd       = sel && (per_we == 2'b00);
   assign wr       = sel && (per_we != 2'b00);
   assign ctl_wr   = sel && per_we[0] && (reg_off == 5'd0);
   assign clr      = ctl_wr && per_din[1];
   assign cnt_en   = gen && !dbg_freeze;
   assign pre_mask = {pre_sel == 2'd3, pre_sel[1], pre_sel != 2'd0};
   assign tick     = (pre_cnt & pre_mask) == pre_mask;
   assign ifg_clr  = (sel && per_we[0] && (reg_off == 5'd3)) ? per_din[NUM_CH-1:0] : '0;

`ifdef PROFILER_SNAPSHOT_EN
   logic [CNT_W-1:0] snap [NUM_CH];
   logic             snap_req;

   assign snap_req = ctl_wr && per_din[5];

   // Snapshot takes the pre-edge value, so a same-cycle increment is excluded.
   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         srd <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) snap[i] <= '0;
      end else begin
         if (ctl_wr) srd <= per_din[6];
         if (snap_req) begin
            for (int i = 0; i < NUM_CH; i++) snap[i] <= cnt[i];
         end
      end
   end
`else
   assign srd = 1'b0;
`endif

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_ext[i] = 32'(cnt[i]);
`ifdef PROFILER_SNAPSHOT_EN
         view[i]    = srd ? 32'(snap[i]) : cnt_ext[i];
`else
         view[i]    = cnt_ext[i];
`endif
         lo_hit[i]  = reg_off == 5'(4 + 2 * i);
         hi_hit[i]  = reg_off == 5'(5 + 2 * i);
         inc[i]     = tick && cnt_en && run[i];
         cnt_wr[i]  = cnt_ext[i];
         if (lo_hit[i]) begin
            if (per_we[0]) cnt_wr[i][7:0]  = per_din[7:0];
            if (per_we[1]) cnt_wr[i][15:8] = per_din[15:8];
         end
         if (hi_hit[i] && (CNT_W == 32)) begin
            if (per_we[0]) cnt_wr[i][23:16] = per_din[7:0];
            if (per_we[1]) cnt_wr[i][31:24] = per_din[15:8];
         end
         wr_hit[i]  = wr && (lo_hit[i] || (hi_hit[i] && (CNT_W == 32)));
         ovf[i]     = inc[i] && !clr && !wr_hit[i] && (cnt[i] == '1);
      end
   end

   // Priority per channel: CLR, then bus write, then increment.
   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i]    <= '0;
            shadow[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (clr)            cnt[i] <= '0;
            else if (wr_hit[i]) cnt[i] <= CNT_W'(cnt_wr[i]);
            else if (inc[i])    cnt[i] <= cnt[i] + 1'b1;
            if (rd && lo_hit[i] && !srd) shadow[i] <= cnt_ext[i][31:16];
         end
      end
   end

   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         gen     <= 1'b0;
         ie      <= 1'b0;
         pre_sel <= 2'd0;
         pre_cnt <= 3'd0;
         run     <= '0;
         ifg     <= '0;
         irq     <= 1'b0;
      end else begin
         if (ctl_wr) begin
            gen     <= per_din[0];
            pre_sel <= per_din[3:2];
            ie      <= per_din[4];
         end
         if (clr)         pre_cnt <= 3'd0;
         else if (cnt_en) pre_cnt <= pre_cnt + 3'd1;
         if (sel && per_we[0] && (reg_off == 5'd1))      run <= run | per_din[NUM_CH-1:0];
         else if (sel && per_we[0] && (reg_off == 5'd2)) run <= run & ~per_din[NUM_CH-1:0];
         ifg <= (ifg & ~ifg_clr) | ovf;
         irq <= ie && (|ifg);
      end
   end

   always_comb begin
      per_dout = '0;
      if (rd) begin
         case (reg_off)
            5'd0: per_dout = {9'd0, srd, 1'b0, ie, pre_sel, 1'b0, gen};
            5'd1: per_dout = 16'(run);
            5'd3: per_dout = 16'(ifg);
            default: begin
               for (int i = 0; i < NUM_CH; i++) begin
                  if (lo_hit[i]) per_dout = view[i][15:0];
                  if (hi_hit[i]) per_dout = srd ? view[i][31:16] : shadow[i];
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_omsp_cycle_profiler.sv
// tb/tb_omsp_cycle_profiler.sv - model-checked directed and random bench for omsp_cycle_profiler
module tb_omsp_cycle_profiler;
   localparam int          NCH   = 4;
   localparam int          CW    = 32;
   localparam logic [14:0] BASE  = 15'h0180;
   localparam logic [13:0] WBASE = 14'h00C0;
   localparam longint      CMAX  = (64'sd1 <<< CW) - 1;
`ifdef PROFILER_SNAPSHOT_EN
   localparam bit SNAP_ON = 1'b1;
`else
   localparam bit SNAP_ON = 1'b0;
`endif

   logic        mclk = 1'b0;
   logic        puc_rst;
   logic [13:0] per_addr;
   logic [15:0] per_din;
   logic        per_en;
   logic [1:0]  per_we;
   logic        dbg_freeze;
   logic [15:0] per_dout;
   logic        irq;

   int total = 0;
   int bad   = 0;

   longint m_cnt [NCH];
   longint m_snap [NCH];
   longint m_shadow [NCH];
   bit     m_run [NCH];
   bit     m_ifg [NCH];
   int     m_gen, m_ie, m_srd, m_pre, m_presc;
   bit     m_irq;

   always #5 mclk = ~mclk;

   omsp_cycle_profiler #(.BASE_ADDR(BASE), .NUM_CH(NCH), .CNT_W(CW)) dut (
      .mclk(mclk), .puc_rst(puc_rst), .per_addr(per_addr), .per_din(per_din),
      .per_en(per_en), .per_we(per_we), .dbg_freeze(dbg_freeze),
      .per_dout(per_dout), .irq(irq)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_cnt[c] = 0; m_snap[c] = 0; m_shadow[c] = 0; m_run[c] = 0; m_ifg[c] = 0;
      end
      m_gen = 0; m_ie = 0; m_srd = 0; m_pre = 0; m_presc = 0; m_irq = 0;
   endtask

   function automatic longint merge(input longint v, input int sh);
      longint r = v;
      if (per_we[0]) r = (r & ~(64'sd255 <<< sh)) | (longint'(per_din[7:0]) <<< sh);
      if (per_we[1]) r = (r & ~(64'sd255 <<< (sh + 8))) | (longint'(per_din[15:8]) <<< (sh + 8));
      return r & CMAX;
   endfunction

   // One clock of the profiler's documented behaviour, evaluated on pre-edge inputs.
   task automatic model_step();
      bit sel, wr, ctlw, clr, snap, tick, counting, any_ifg;
      bit ovf [NCH];
      int off, div;
      sel      = per_en && (per_addr[13:5] == BASE[14:6]);
      off      = int'(per_addr[4:0]);
      wr       = sel && (per_we != 2'b00);
      ctlw     = sel && per_we[0] && (off == 0);
      clr      = ctlw && per_din[1];
      snap     = SNAP_ON && ctlw && per_din[5];
      div      = 1 << m_pre;
      tick     = (m_presc % div) == (div - 1);
      counting = (m_gen != 0) && !dbg_freeze;
      any_ifg  = 0;
      for (int c = 0; c < NCH; c++) any_ifg |= m_ifg[c];
      for (int c = 0; c < NCH; c++) begin
         ovf[c] = 0;
         if (snap) m_snap[c] = m_cnt[c];
         if (sel && per_we == 2'b00 && off == 4 + 2 * c && m_srd == 0)
            m_shadow[c] = (m_cnt[c] >> 16) & 16'hFFFF;
         if (clr) m_cnt[c] = 0;
         else if (wr && off == 4 + 2 * c) m_cnt[c] = merge(m_cnt[c], 0);
         else if (wr && off == 5 + 2 * c && CW == 32) m_cnt[c] = merge(m_cnt[c], 16);
         else if (counting && tick && m_run[c]) begin
            if (m_cnt[c] == CMAX) begin
               m_cnt[c] = 0;
               ovf[c] = 1;
            end else m_cnt[c] = m_cnt[c] + 1;
         end
      end
      for (int c = 0; c < NCH; c++) begin
         if (sel && per_we[0] && off == 1 && per_din[c]) m_run[c] = 1;
         if (sel && per_we[0] && off == 2 && per_din[c]) m_run[c] = 0;
         if (sel && per_we[0] && off == 3 && per_din[c]) m_ifg[c] = 0;
         if (ovf[c]) m_ifg[c] = 1;
      end
      m_irq = (m_ie != 0) && any_ifg;
      if (ctlw) begin
         m_gen = per_din[0];
         m_pre = per_din[3:2];
         m_ie  = per_din[4];
         if (SNAP_ON) m_srd = per_din[6];
      end
      if (clr) m_presc = 0;
      else if (counting) m_presc = (m_presc + 1) % 8;
   endtask

   function automatic logic [15:0] m_read();
      int off, c;
      longint v;
      logic [15:0] bits;
      if (!(per_en && per_addr[13:5] == BASE[14:6] && per_we == 2'b00)) return 16'h0000;
      off = int'(per_addr[4:0]);
      bits = 16'h0000;
      if (off == 0) return 16'(m_gen | (m_pre << 2) | (m_ie << 4) | (m_srd << 6));
      if (off == 1) begin
         for (int k = 0; k < NCH; k++) bits[k] = m_run[k];
         return bits;
      end
      if (off == 3) begin
         for (int k = 0; k < NCH; k++) bits[k] = m_ifg[k];
         return bits;
      end
      if (off >= 4 && off < 4 + 2 * NCH) begin
         c = (off - 4) / 2;
         v = (m_srd != 0) ? m_snap[c] : m_cnt[c];
         if (off % 2 == 0) return 16'(v & 16'hFFFF);
         return (m_srd != 0) ? 16'((v >> 16) & 16'hFFFF) : 16'(m_shadow[c]);
      end
      return 16'h0000;
   endfunction

   initial begin
      forever begin
         @(negedge mclk);
         #2;
         if (!puc_rst) begin
            check("dout", 32'(per_dout), 32'(m_read()));
            check("irq", 32'(irq), 32'(m_irq));
         end
      end
   end

   task automatic cyc(input logic [13:0] a, input logic [15:0] d, input logic en,
                      input logic [1:0] we, input logic frz, output logic [15:0] rdv);
      per_addr = a; per_din = d; per_en = en; per_we = we; dbg_freeze = frz;
      #1 rdv = per_dout;
      @(posedge mclk);
      model_step();
      @(negedge mclk);
   endtask

   task automatic wr(input int off, input logic [15:0] d);
      logic [15:0] dummy;
      cyc(WBASE + 14'(off), d, 1'b1, 2'b11, 1'b0, dummy);
   endtask

   task automatic rd(input int off, output logic [15:0] v);
      cyc(WBASE + 14'(off), 16'h0000, 1'b1, 2'b00, 1'b0, v);
   endtask

   task automatic idle(input logic frz);
      logic [15:0] dummy;
      cyc(14'h0000, 16'h0000, 1'b0, 2'b00, frz, dummy);
   endtask

   task automatic do_reset();
      per_en = 1'b0; per_we = 2'b00; dbg_freeze = 1'b0;
      #3 puc_rst = 1'b1;
      model_reset();
      @(negedge mclk);
      #3 puc_rst = 1'b0;
      @(posedge mclk);
      model_step();
      @(negedge mclk);
   endtask

   initial begin
      logic [15:0] r, d;
      logic [13:0] a;
      logic [1:0]  we;
      logic        frz;
      per_addr = '0; per_din = '0; per_en = 1'b0; per_we = 2'b00; dbg_freeze = 1'b0;
      puc_rst = 1'b1;
      model_reset();
      repeat (3) @(negedge mclk);
      puc_rst = 1'b0;

      for (int o = 0; o < 20; o++) begin
         rd(o, r);
         check("reset_read", 32'(r), 32'h0);
      end
      check("reset_irq", 32'(irq), 32'h0);

      wr(0, 16'h0001); wr(1, 16'h0001);
      repeat (100) idle(1'b0);
      wr(2, 16'h0001);
      rd(4, r); check("ch0_lo_run", 32'(r), 32'd101);
      rd(5, r); check("ch0_hi_run", 32'(r), 32'h0);
      rd(6, r); check("ch1_idle", 32'(r), 32'h0);
      rd(8, r); check("ch2_idle", 32'(r), 32'h0);
      rd(10, r); check("ch3_idle", 32'(r), 32'h0);

      wr(0, 16'h000F); wr(1, 16'h0004);
      repeat (79) idle(1'b0);
      wr(2, 16'h0004);
      rd(8, r); check("pre8_count", 32'(r), 32'd10);

      wr(0, 16'h000F); wr(1, 16'h0004);
      repeat (40) idle(1'b1);
      repeat (39) idle(1'b0);
      wr(2, 16'h0004);
      rd(8, r); check("pre8_freeze", 32'(r), 32'd5);

      wr(0, 16'h0011); wr(6, 16'hFFFE); wr(7, 16'hFFFF); wr(1, 16'h0002);
      idle(1'b0); idle(1'b0);
      check("irq_lag", 32'(irq), 32'h0);
      rd(3, r); check("ifg_ovf", 32'(r), 32'h2);
      check("irq_set", 32'(irq), 32'h1);
      wr(2, 16'h0002);
      rd(6, r); check("ch1_wrapped", 32'(r), 32'd2);
      wr(3, 16'h0002); idle(1'b0);
      check("irq_clr", 32'(irq), 32'h0);

      wr(7, 16'hFFFF); wr(6, 16'hFFFF); wr(1, 16'h0002);
      wr(3, 16'h0002);
      rd(3, r); check("ifg_set_wins", 32'(r), 32'h2);
      wr(2, 16'h0002);

      wr(5, 16'h0000); wr(4, 16'hFFFF); wr(1, 16'h0001);
      rd(4, r); check("coh_lo", 32'(r), 32'hFFFF);
      repeat (5) idle(1'b0);
      rd(5, r); check("coh_hi", 32'(r), 32'h0000);
      wr(2, 16'h0001);

      wr(0, 16'h0013);
      rd(4, r); check("clr_live", 32'(r), 32'h0);
      rd(3, r); check("clr_keeps_ifg", 32'(r), 32'h2);

`ifdef PROFILER_SNAPSHOT_EN
      wr(0, 16'h0013); wr(1, 16'h000F);
      repeat (9) idle(1'b0);
      wr(0, 16'h0031);
      repeat (50) idle(1'b0);
      wr(0, 16'h0051);
      for (int c = 0; c < NCH; c++) begin
         rd(4 + 2 * c, r); check("snap_lo", 32'(r), 32'd9);
         rd(5 + 2 * c, r); check("snap_hi", 32'(r), 32'h0);
      end
      wr(0, 16'h0013);
      rd(4, r); check("snap_clr_live", 32'(r), 32'h0);
      rd(3, r); check("snap_clr_ifg", 32'(r), 32'h2);
      wr(2, 16'h000F);
`endif

      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) begin
            do_reset();
            rd(0, r); check("midreset_ctl", 32'(r), 32'h0);
            check("midreset_irq", 32'(irq), 32'h0);
         end
         frz = ($urandom_range(0, 9) == 0);
         a   = WBASE + 14'($urandom_range(0, 23));
         if ($urandom_range(0, 9) == 0) a = 14'($urandom);
         d   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
         case ($urandom_range(0, 3))
            0, 1: idle(frz);
            2: cyc(a, 16'h0000, 1'b1, 2'b00, frz, r);
            default: begin
               we = 2'($urandom_range(1, 3));
               cyc(a, d, 1'b1, we, frz, r);
            end
         endcase
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
